// File: rtl/ngc_pwm_gen.sv
// ngc_pwm_gen: double-buffered compare stage that turns the ngc counter's
// count/count_hit into a complementary PWM pair with optional dead-time.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enb             output enable; low forces both pins inactive
//   count           counter value from the ngc counter
//   count_hit       period boundary pulse from the ngc counter
//   duty_value      new duty, captured into the shadow on duty_load
//   duty_load       single-cycle shadow write strobe
//   deadtime_value  dead-time in clk cycles, sampled at each dead-time start
//   polarity        0 = active-high pins, 1 = active-low pins
//   pwm_h, pwm_l    high-side / low-side PWM pins
//   period_end      registered copy of count_hit
//   duty_pending    shadow holds a value not yet transferred
//
// Build option: define NGC_PWM_DEADTIME_EN to include the dead-time FSM.
module ngc_pwm_gen #(
    parameter int COUNT_WIDTH    = 8,
    parameter int DEADTIME_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic [COUNT_WIDTH-1:0]    count,
    input  logic                      count_hit,
    input  logic [COUNT_WIDTH-1:0]    duty_value,
    input  logic                      duty_load,
    input  logic [DEADTIME_WIDTH-1:0] deadtime_value,
    input  logic                      polarity,
    output logic                      pwm_h,
    output logic                      pwm_l,
    output logic                      period_end,
    output logic                      duty_pending
);

    logic [COUNT_WIDTH-1:0] r_duty_shadow;
    logic [COUNT_WIDTH-1:0] r_duty_active;
    logic                   r_duty_pending;
    logic                   r_raw_q;
    logic                   r_period_end;
    logic                   r_h;
    logic                   r_l;
    logic                   w_raw_d;

    // All-ones duty is forced to 100% since count never exceeds all-ones.
    assign w_raw_d = enb & ((count < r_duty_active) |
                            (r_duty_active == '1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_shadow  <= '0;
            r_duty_active  <= '0;
            r_duty_pending <= 1'b0;
            r_raw_q        <= 1'b0;
            r_period_end   <= 1'b0;
        end else begin
            r_raw_q      <= w_raw_d;
            r_period_end <= count_hit;
            if (duty_load && count_hit) begin
                // Write on the boundary bypasses the shadow entirely.
                r_duty_shadow  <= duty_value;
                r_duty_active  <= duty_value;
                r_duty_pending <= 1'b0;
            end else if (duty_load) begin
                r_duty_shadow  <= duty_value;
                r_duty_pending <= 1'b1;
            end else if (count_hit && r_duty_pending) begin
                r_duty_active  <= r_duty_shadow;
                r_duty_pending <= 1'b0;
            end
        end
    end

`ifdef NGC_PWM_DEADTIME_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH_ON,
        S_LOW_ON,
        S_DEAD_TO_H,
        S_DEAD_TO_L
    } state_t;

    state_t                    r_state;
    logic [DEADTIME_WIDTH-1:0] r_dead_cnt;
    logic                      w_dt_zero;
    logic                      w_dead_last;

    assign w_dt_zero   = (deadtime_value == '0);
    // A count of 1 or less means this cycle ends the dead band.
    assign w_dead_last = (r_dead_cnt <= DEADTIME_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dead_cnt <= '0;
            r_h        <= 1'b0;
            r_l        <= 1'b0;
        end else if (!enb) begin
            r_state    <= S_IDLE;
            r_dead_cnt <= '0;
            r_h        <= 1'b0;
            r_l        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state <= r_raw_q ? S_HIGH_ON : S_LOW_ON;
                    r_h     <= r_raw_q;
                    r_l     <= ~r_raw_q;
                end
                S_HIGH_ON: begin
                    if (!r_raw_q) begin
                        r_h <= 1'b0;
                        if (w_dt_zero) begin
                            r_state <= S_LOW_ON;
                            r_l     <= 1'b1;
                        end else begin
                            r_state    <= S_DEAD_TO_L;
                            r_dead_cnt <= deadtime_value;
                        end
                    end
                end
                S_LOW_ON: begin
                    if (r_raw_q) begin
                        r_l <= 1'b0;
                        if (w_dt_zero) begin
                            r_state <= S_HIGH_ON;
                            r_h     <= 1'b1;
                        end else begin
                            r_state    <= S_DEAD_TO_H;
                            r_dead_cnt <= deadtime_value;
                        end
                    end
                end
                S_DEAD_TO_L: begin
                    if (r_raw_q) begin
                        // Compare flipped back: head for the high side.
                        if (w_dt_zero) begin
                            r_state <= S_HIGH_ON;
                            r_h     <= 1'b1;
                        end else begin
                            r_state    <= S_DEAD_TO_H;
                            r_dead_cnt <= deadtime_value;
                        end
                    end else if (w_dead_last) begin
                        r_state    <= S_LOW_ON;
                        r_dead_cnt <= '0;
                        r_l        <= 1'b1;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - 1'b1;
                    end
                end
                S_DEAD_TO_H: begin
                    if (!r_raw_q) begin
                        if (w_dt_zero) begin
                            r_state <= S_LOW_ON;
                            r_l     <= 1'b1;
                        end else begin
                            r_state    <= S_DEAD_TO_L;
                            r_dead_cnt <= deadtime_value;
                        end
                    end else if (w_dead_last) begin
                        r_state    <= S_HIGH_ON;
                        r_dead_cnt <= '0;
                        r_h        <= 1'b1;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_dead_cnt <= '0;
                    r_h        <= 1'b0;
                    r_l        <= 1'b0;
                end
            endcase
        end
    end
`else
    logic w_unused_deadtime;

    assign w_unused_deadtime = ^deadtime_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= 1'b0;
            r_l <= 1'b0;
        end else begin
            r_h <= enb & r_raw_q;
            r_l <= enb & ~r_raw_q;
        end
    end
`endif

    assign pwm_h        = r_h ^ polarity;
    assign pwm_l        = r_l ^ polarity;
    assign period_end   = r_period_end;
    assign duty_pending = r_duty_pending;

endmodule

// File: tb/tb_ngc_pwm_gen.sv
// tb_ngc_pwm_gen: directed bench for ngc_pwm_gen driven by a 0..9 counter
// with count_hit at 9; duty table plus buffering/dead-time/reset sequences.
`timescale 1ns/1ps
module tb_ngc_pwm_gen;
    localparam int CW = 8;
    localparam int DW = 4;
`ifdef NGC_PWM_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic [CW-1:0] count;
    logic          count_hit;
    logic [CW-1:0] duty_value;
    logic          duty_load;
    logic [DW-1:0] deadtime_value;
    logic          polarity;
    logic          pwm_h;
    logic          pwm_l;
    logic          period_end;
    logic          duty_pending;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    int h1 = 0;
    int h2 = 0;

    typedef struct {
        logic [CW-1:0] duty;
        logic          pol;
        int            exp_hi;
    } vec_t;

    vec_t tbl [0:6];

    always #5 clk = ~clk;

    ngc_pwm_gen #(
        .COUNT_WIDTH(CW),
        .DEADTIME_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .count(count),
        .count_hit(count_hit),
        .duty_value(duty_value),
        .duty_load(duty_load),
        .deadtime_value(deadtime_value),
        .polarity(polarity),
        .pwm_h(pwm_h),
        .pwm_l(pwm_l),
        .period_end(period_end),
        .duty_pending(duty_pending)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; afterwards pins reflect the count applied two ticks ago (h2).
    task automatic tick();
        @(posedge clk);
        #1;
        h2 = h1;
        h1 = cnt;
        cnt = (cnt == 9) ? 0 : cnt + 1;
        count = CW'(cnt);
        count_hit = (cnt == 9);
        checks++;
        if ((pwm_h ^ polarity) && (pwm_l ^ polarity)) begin
            errors++;
            $display("FAIL overlap: got h=%0b l=%0b both active",
                     pwm_h, pwm_l);
        end
    endtask

    task automatic measure(input int n, input logic [CW-1:0] d,
                           input logic chk_lag, output int nh,
                           output int nl, output int nb);
        logic e;
        nh = 0;
        nl = 0;
        nb = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (pwm_h ^ polarity) nh++;
            if (pwm_l ^ polarity) nl++;
            if (!(pwm_h ^ polarity) && !(pwm_l ^ polarity)) nb++;
            if (chk_lag) begin
                e = (h2 < int'(d)) || (d == '1);
                check("lag", pwm_h, e ^ polarity);
                check("compl", pwm_l, !pwm_h);
            end
        end
    endtask

    task automatic load(input logic [CW-1:0] d);
        duty_value = d;
        duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
    endtask

    int   nh, nl, nb, n;
    logic found, rose;

    initial begin
        tbl[0] = '{duty: 8'd4,   pol: 1'b0, exp_hi: 4};
        tbl[1] = '{duty: 8'd7,   pol: 1'b0, exp_hi: 7};
        tbl[2] = '{duty: 8'd0,   pol: 1'b0, exp_hi: 0};
        tbl[3] = '{duty: 8'hFF,  pol: 1'b0, exp_hi: 10};
        tbl[4] = '{duty: 8'd4,   pol: 1'b1, exp_hi: 4};
        tbl[5] = '{duty: 8'd10,  pol: 1'b0, exp_hi: 10};
        tbl[6] = '{duty: 8'd1,   pol: 1'b0, exp_hi: 1};

        rst = 1'b1;
        enb = 1'b1;
        polarity = 1'b1;
        count = '0;
        count_hit = 1'b0;
        duty_value = '0;
        duty_load = 1'b0;
        deadtime_value = '0;

        repeat (3) tick();
        check("rst_pwm_h", pwm_h, 1);
        check("rst_pwm_l", pwm_l, 1);
        check("rst_period_end", period_end, 0);
        check("rst_pending", duty_pending, 0);
        polarity = 1'b0;
        rst = 1'b0;

        // Duty table: steady-state high count, 2-cycle lag, complement.
        for (int i = 0; i < 7; i++) begin
            polarity = tbl[i].pol;
            load(tbl[i].duty);
            repeat (25) tick();
            measure(10, tbl[i].duty, 1'b1, nh, nl, nb);
            check($sformatf("duty_hi[%0d]", i), nh, tbl[i].exp_hi);
        end

        // Double buffering: 4 stays until the boundary, then 7.
        polarity = 1'b0;
        load(8'd4);
        repeat (25) tick();
        n = 0;
        while (cnt != 3 && n < 12) begin
            tick();
            n++;
        end
        check("wait_cnt3", cnt, 3);
        load(8'd7);
        check("pend_rise", duty_pending, 1);
        found = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            if (count_hit) begin
                tick();
                found = 1'b1;
                check("pend_fall", duty_pending, 0);
            end else begin
                tick();
                check("pend_hold", duty_pending, 1);
                check("db_old", pwm_h, (h2 < 4));
            end
        end
        check("wait_hit_db", found, 1);
        tick();
        check("db_edge", pwm_h, 0);
        measure(10, 8'd7, 1'b1, nh, nl, nb);
        check("db_new_hi", nh, 7);

        // Load coinciding with count_hit goes straight to active.
        n = 0;
        while (!count_hit && n < 12) begin
            tick();
            n++;
        end
        check("wait_hit_sc", count_hit, 1);
        load(8'd2);
        check("sc_pend", duty_pending, 0);
        check("pe_high", period_end, 1);
        tick();
        check("pe_low", period_end, 0);
        rose = 1'b0;
        nh = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (duty_pending) rose = 1'b1;
            if (pwm_h) nh++;
        end
        check("sc_hi", nh, 2);
        check("sc_no_pend", rose, 0);

        // Enable dropped while the high side is on.
        n = 0;
        while (!pwm_h && n < 12) begin
            tick();
            n++;
        end
        check("wait_h_enb", pwm_h, 1);
        enb = 1'b0;
        tick();
        check("enb_h", pwm_h, 0);
        check("enb_l", pwm_l, 0);
        tick();
        check("enb_h2", pwm_h, 0);
        check("enb_l2", pwm_l, 0);
        enb = 1'b1;
        repeat (25) tick();
        check("enb_resume", pwm_l, !pwm_h);

        // Dead-time 3 with duty 5 over two full periods.
        deadtime_value = 4'd3;
        load(8'd5);
        repeat (30) tick();
        measure(20, 8'd5, 1'b0, nh, nl, nb);
        check("dt_hi", nh, DT_EN ? 4 : 10);
        check("dt_lo", nl, DT_EN ? 4 : 10);
        check("dt_both_low", nb, DT_EN ? 12 : 0);

        // Asynchronous reset while high side on with a pending duty.
        n = 0;
        while (!pwm_h && n < 12) begin
            tick();
            n++;
        end
        check("wait_h_rst", pwm_h, 1);
        load(8'd6);
        check("rst_a_pend_pre", duty_pending, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_a_pend", duty_pending, 0);
        check("rst_a_h", pwm_h, 0);
        check("rst_a_l", pwm_l, 0);
        check("rst_a_pe", period_end, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (25) tick();
        measure(10, 8'd0, 1'b0, nh, nl, nb);
        check("rst_a_zero_hi", nh, 0);
        check("rst_a_zero_lo", nl, 10);

        // Asynchronous reset in a dead band (or mid-high without dead-time).
        load(8'd5);
        repeat (30) tick();
        n = 0;
        if (DT_EN) begin
            while ((pwm_h || pwm_l) && n < 12) begin
                tick();
                n++;
            end
            check("wait_dead", pwm_h | pwm_l, 0);
        end else begin
            while (!pwm_h && n < 12) begin
                tick();
                n++;
            end
            check("wait_h_rst_b", pwm_h, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_b_h", pwm_h, 0);
        check("rst_b_l", pwm_l, 0);
        repeat (2) tick();
        rst = 1'b0;
        load(8'd5);
        repeat (30) tick();
        measure(10, 8'd5, 1'b0, nh, nl, nb);
        check("rst_b_hi", nh, DT_EN ? 2 : 5);
        check("rst_b_both_low", nb, DT_EN ? 6 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
